// File: rtl/lcd_text_engine_pkg.sv
// lcd_pkg: shared constants, enums and helpers for the character-LCD text engine.
package lcd_pkg;
    localparam int         INIT_LEN      = 4;
    localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] INIT_CMD [INIT_LEN] = '{CMD_FUNC_SET, CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY};
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] ROW_BASE [4]  = '{8'h00, 8'h40, 8'h14, 8'h54};
    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    typedef enum logic [1:0] {P_INIT, P_ROWADDR, P_CHAR} phase_e;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_NEXT} state_e;
    // Index width with a floor of one bit so single-entry dimensions still get a port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/lcd_text_engine_if.sv
// lcd_text_engine_if: framebuffer write port plus LCD_Controller handshake.
//   master: the engine (drives oREADY/oBUSY/oDATA/oRS/oSTART, receives writes and iDONE)
//   slave : game logic + controller side
//   LCD_NUM_FIELD_EN adds the iNUM_* two-digit number write port.
interface lcd_text_engine_if import lcd_pkg::*; #(
    parameter int ROWS = 2,
    parameter int COLS = 16
);
    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);
    logic          iWR;
    logic [RW-1:0] iWR_ROW;
    logic [CW-1:0] iWR_COL;
    logic [7:0]    iWR_CHAR;
`ifdef LCD_NUM_FIELD_EN
    logic          iNUM_WR;
    logic [RW-1:0] iNUM_ROW;
    logic [CW-1:0] iNUM_COL;
    logic [6:0]    iNUM_VAL;
`endif
    logic          oREADY;
    logic          oBUSY;
    logic [7:0]    oDATA;
    logic          oRS;
    logic          oSTART;
    logic          iDONE;
    modport master (
`ifdef LCD_NUM_FIELD_EN
        input  iNUM_WR, iNUM_ROW, iNUM_COL, iNUM_VAL,
`endif
        input  iWR, iWR_ROW, iWR_COL, iWR_CHAR, iDONE,
        output oREADY, oBUSY, oDATA, oRS, oSTART
    );
    modport slave (
`ifdef LCD_NUM_FIELD_EN
        output iNUM_WR, iNUM_ROW, iNUM_COL, iNUM_VAL,
`endif
        output iWR, iWR_ROW, iWR_COL, iWR_CHAR, iDONE,
        input  oREADY, oBUSY, oDATA, oRS, oSTART
    );
endinterface

// File: rtl/lcd_text_engine_row_arbiter.sv
// lcd_row_arbiter: picks the lowest-indexed set bit of the dirty-row vector.
//   dirty in  ROWS  dirty flags
//   valid out 1     any row dirty
//   row   out RW    lowest dirty row (0 when none)
module lcd_row_arbiter #(
    parameter int ROWS = 2,
    parameter int RW   = 1
) (
    input  logic [ROWS-1:0] dirty,
    output logic            valid,
    output logic [RW-1:0]   row
);
    always_comb begin
        valid = |dirty;
        row   = '0;
        for (int i = ROWS - 1; i >= 0; i--)
            if (dirty[i]) row = RW'(i);
    end
endmodule

// File: rtl/lcd_text_engine.sv
// lcd_text_engine: ROWS x COLS character framebuffer with dirty-row refresh to an HD44780 via LCD_Controller.
//   iCLK   in  clock
//   iRST_N in  asynchronous active-low reset
//   bus    lcd_text_engine_if.master: iWR/iWR_ROW/iWR_COL/iWR_CHAR writes, oREADY, oBUSY,
//          oDATA/oRS/oSTART/iDONE controller handshake
//   Optional LCD_NUM_FIELD_EN: iNUM_WR/iNUM_ROW/iNUM_COL/iNUM_VAL two-digit number writes.
module lcd_text_engine import lcd_pkg::*; #(
    parameter int ROWS       = 2,
    parameter int COLS       = 16,
    parameter int DLY_CYCLES = 262142
) (
    input logic               iCLK,
    input logic               iRST_N,
    lcd_text_engine_if.master bus
);
    localparam int RW = idx_w(ROWS);
    localparam int CW = idx_w(COLS);
    localparam int IW = idx_w(COLS > INIT_LEN ? COLS : INIT_LEN);
    localparam int DW = idx_w(DLY_CYCLES);

    state_e          state_q, state_d;
    phase_e          phase_q, phase_d;
    logic [IW-1:0]   item_q, item_d;
    logic [RW-1:0]   row_q, row_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic [7:0]      data_q, data_d;
    logic            rs_q, rs_d;
    logic            start_q, start_d;
    logic [ROWS-1:0] dirty_q, dirty_d;
    logic [7:0]      fb_q [ROWS][COLS];
    logic [7:0]      fb_d [ROWS][COLS];
    logic            arb_valid;
    logic [RW-1:0]   arb_row;

    lcd_row_arbiter #(.ROWS(ROWS), .RW(RW)) u_arb (
        .dirty (dirty_q),
        .valid (arb_valid),
        .row   (arb_row)
    );

`ifdef LCD_NUM_FIELD_EN
    logic [6:0] num_v;
    logic [7:0] num_tens, num_ones;
    assign num_v    = (bus.iNUM_VAL > 7'd99) ? 7'd99 : bus.iNUM_VAL;
    assign num_tens = 8'h30 + 8'(num_v / 7'd10);
    assign num_ones = 8'h30 + 8'(num_v % 7'd10);
`endif

    assign bus.oREADY = ready_q;
    assign bus.oBUSY  = (state_q != S_IDLE) || (|dirty_q);
    assign bus.oDATA  = data_q;
    assign bus.oRS    = rs_q;
    assign bus.oSTART = start_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        item_d  = item_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        data_d  = data_q;
        rs_d    = rs_q;
        start_d = start_q;
        dirty_d = dirty_q;
        fb_d    = fb_q;
        case (state_q)
            S_ISSUE: begin
                start_d = 1'b1;
                state_d = S_WAIT;
                if (phase_q == P_INIT) begin
                    data_d = INIT_CMD[2'(item_q)];
                    rs_d   = 1'b0;
                end else if (phase_q == P_ROWADDR) begin
                    // Clearing here means any write arriving during the row's bytes re-marks it.
                    row_d            = arb_row;
                    dirty_d[arb_row] = 1'b0;
                    data_d           = CMD_SET_DDRAM | ROW_BASE[2'(arb_row)];
                    rs_d             = 1'b0;
                end else begin
                    data_d = fb_q[row_q][CW'(item_q)];
                    rs_d   = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.iDONE) begin
                    start_d = 1'b0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == DW'(DLY_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            S_NEXT: begin
                if (phase_q == P_ROWADDR) begin
                    phase_d = P_CHAR;
                    item_d  = '0;
                    state_d = S_ISSUE;
                end else if ((phase_q == P_INIT && item_q == IW'(INIT_LEN - 1)) ||
                             (phase_q == P_CHAR && item_q == IW'(COLS - 1))) begin
                    ready_d = 1'b1;
                    phase_d = P_ROWADDR;
                    item_d  = '0;
                    state_d = arb_valid ? S_ISSUE : S_IDLE;
                end else begin
                    item_d  = item_q + IW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_IDLE: begin
                start_d = 1'b0;
                if (arb_valid) begin
                    phase_d = P_ROWADDR;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Writes come after the dirty-clear so a same-cycle set on the same row wins.
        if (bus.iWR && int'(bus.iWR_ROW) < ROWS && int'(bus.iWR_COL) < COLS) begin
            fb_d[bus.iWR_ROW][bus.iWR_COL] = bus.iWR_CHAR;
            dirty_d[bus.iWR_ROW]           = 1'b1;
        end
`ifdef LCD_NUM_FIELD_EN
        if (bus.iNUM_WR && int'(bus.iNUM_ROW) < ROWS && int'(bus.iNUM_COL) < COLS) begin
            fb_d[bus.iNUM_ROW][bus.iNUM_COL] = num_tens;
            dirty_d[bus.iNUM_ROW]            = 1'b1;
            if (int'(bus.iNUM_COL) + 1 < COLS)
                fb_d[bus.iNUM_ROW][bus.iNUM_COL + CW'(1)] = num_ones;
        end
`endif
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_ISSUE;
            phase_q <= P_INIT;
            item_q  <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            start_q <= 1'b0;
            dirty_q <= '1;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    fb_q[r][c] <= ASCII_SPACE;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            item_q  <= item_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            start_q <= start_d;
            dirty_q <= dirty_d;
            fb_q    <= fb_d;
        end
    end
endmodule
